// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the decode-stage hazard controller.
//   - opcode constants for the instructions that need special handling
//   - instr_class_t: how an instruction uses the register file
//   - state_t: controller FSM states
//   - decode_class(): opcode to class mapping (unlisted opcodes are ALU)
package hazard_pkg;

    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_LW  = 5'h10;
    localparam logic [4:0] OP_SW  = 5'h11;
    localparam logic [4:0] OP_BEQ = 5'h12;
    localparam logic [4:0] OP_JMP = 5'h13;

    typedef enum logic [2:0] {
        ALU,
        LW,
        SW,
        BEQ,
        JMP,
        NOP
    } instr_class_t;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } state_t;

    // Anything that is not one of the special opcodes behaves like an
    // ALU op: two reads and a write to rd.
    function automatic instr_class_t decode_class(input logic [4:0] op);
        instr_class_t cls;
        case (op)
            OP_NOP:  cls = NOP;
            OP_LW:   cls = LW;
            OP_SW:   cls = SW;
            OP_BEQ:  cls = BEQ;
            OP_JMP:  cls = JMP;
            default: cls = ALU;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks which registers have a write in flight.
//   clk, rst        clock, asynchronous active-high reset
//   set_en, set_idx an issued writer targets register set_idx
//   clr_en, clr_idx writeback commits to register clr_idx
//   pending[15:0]   bit n = register n has an outstanding write
//   inflight[3:0]   number of outstanding writers, 0..MAX_INFLIGHT
//   wb_err          sticky: writeback hit a register that was not pending
//                   (or collided with a same-cycle set of that register)
module hazard_scoreboard #(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en,
    input  logic [3:0]  set_idx,
    input  logic        clr_en,
    input  logic [3:0]  clr_idx,
    output logic [15:0] pending,
    output logic [3:0]  inflight,
    output logic        wb_err
);

    logic [15:0] set_mask;
    logic [15:0] clr_mask;
    logic        collision;
    logic        clr_valid;
    logic        clr_bad;

    // A set and clear of the same register in one cycle keeps the set and
    // drops the clear; the clear is then reported as an error because the
    // WAW check should have made the pair impossible.
    always_comb begin
        set_mask  = '0;
        clr_mask  = '0;
        collision = set_en && clr_en && (set_idx == clr_idx);
        clr_valid = clr_en && pending[clr_idx] && !collision;
        clr_bad   = clr_en && (!pending[clr_idx] || collision);
        if (set_en) begin
            set_mask = 16'h0001 << set_idx;
        end
        if (clr_valid) begin
            clr_mask = 16'h0001 << clr_idx;
        end
    end

    // Scoreboard bits, writer count and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            inflight <= '0;
            wb_err   <= 1'b0;
        end else begin
            pending <= (pending | set_mask) & ~clr_mask;
            if (set_en && !clr_valid) begin
                if (inflight < 4'(MAX_INFLIGHT)) begin
                    inflight <= inflight + 4'd1;
                end
            end else if (clr_valid && !set_en) begin
                if (inflight != 4'd0) begin
                    inflight <= inflight - 4'd1;
                end
            end
            if (clr_bad) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: decode-stage sequencer between IF/ID and ID/EXE.
// Stalls on RAW/WAW hazards or when the in-flight writer limit is reached,
// holds branches until their operands are clean and flushes IF/ID after a
// taken branch or jump.
//   clk, rst                 clock, asynchronous active-high reset
//   instr_valid, opcode,
//   rs_dir, rt_dir, rd_dir   instruction held in IF/ID
//   flag_branch              comparator equal flag for BEQ
//   reg_wr, dir_wb           register-file writeback port
//   issue, stall, bubble     pipeline control
//   flush, take_branch       IF/ID kill and PC target select
//   pending, inflight, wb_err scoreboard state
// Optional: define HAZARD_PERF_EN to add saturating 32-bit stall_cnt and
// flush_cnt cycle counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [4:0]  opcode,
    input  logic [3:0]  rs_dir,
    input  logic [3:0]  rt_dir,
    input  logic [3:0]  rd_dir,
    input  logic        flag_branch,
    input  logic        reg_wr,
    input  logic [3:0]  dir_wb,
    output logic        issue,
    output logic        stall,
    output logic        bubble,
    output logic        flush,
    output logic        take_branch,
    output logic [15:0] pending,
    output logic [3:0]  inflight,
    output logic        wb_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    state_t       state;
    state_t       next_state;
    instr_class_t cls;
    logic         reads_rs;
    logic         reads_rt;
    logic         is_writer;
    logic [3:0]   dest;
    logic [15:0]  live_pending;
    logic         wb_valid;
    logic [3:0]   eff_inflight;
    logic         raw;
    logic         waw;
    logic         full;
    logic         hazard;
    logic         taken;
    logic [1:0]   flush_timer;

    // Register usage of the instruction currently in IF/ID.
    always_comb begin
        cls       = decode_class(opcode);
        reads_rs  = 1'b0;
        reads_rt  = 1'b0;
        is_writer = 1'b0;
        dest      = rd_dir;
        case (cls)
            ALU: begin
                reads_rs  = 1'b1;
                reads_rt  = 1'b1;
                is_writer = 1'b1;
            end
            LW: begin
                reads_rs  = 1'b1;
                is_writer = 1'b1;
                dest      = rt_dir;
            end
            SW, BEQ: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // A writeback landing this cycle makes its register readable now, so
    // RAW and the writer limit see it immediately. WAW deliberately uses the
    // registered bits: letting a writer reclaim a register in the same cycle
    // its previous write retires would set and clear the same bit at once.
    always_comb begin
        live_pending = pending;
        wb_valid     = reg_wr && pending[dir_wb] && (inflight != 4'd0);
        if (reg_wr) begin
            live_pending = pending & ~(16'h0001 << dir_wb);
        end
        eff_inflight = inflight - 4'(wb_valid);
        raw    = (reads_rs && live_pending[rs_dir]) || (reads_rt && live_pending[rt_dir]);
        waw    = is_writer && pending[dest];
        full   = is_writer && (eff_inflight >= 4'(MAX_INFLIGHT));
        hazard = raw || waw || full;
        taken  = ((cls == BEQ) && flag_branch) || (cls == JMP);
    end

    // RUN and STALL resolve the same way each cycle; STALL only records that
    // the instruction in IF/ID is being held. FLUSH ignores IF/ID entirely.
    always_comb begin
        next_state  = state;
        issue       = 1'b0;
        stall       = 1'b0;
        bubble      = 1'b0;
        take_branch = 1'b0;
        case (state)
            RUN, STALL: begin
                next_state = RUN;
                if (instr_valid) begin
                    if (hazard) begin
                        stall      = 1'b1;
                        bubble     = 1'b1;
                        next_state = STALL;
                    end else begin
                        issue = 1'b1;
                        if (taken) begin
                            take_branch = 1'b1;
                            next_state  = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                bubble = 1'b1;
                if (flush_timer == 2'(FLUSH_CYCLES - 1)) begin
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    assign flush = (state == FLUSH);

    // State register and count of flush cycles already spent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            flush_timer <= '0;
        end else begin
            state <= next_state;
            if ((state == FLUSH) && (next_state == FLUSH)) begin
                flush_timer <= flush_timer + 2'd1;
            end else begin
                flush_timer <= '0;
            end
        end
    end

    hazard_scoreboard #(
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue && is_writer),
        .set_idx  (dest),
        .clr_en   (reg_wr),
        .clr_idx  (dir_wb),
        .pending  (pending),
        .inflight (inflight),
        .wb_err   (wb_err)
    );

`ifdef HAZARD_PERF_EN
    // Saturating cycle counters for stall and flush activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Sequences the decode stage: tracks in-flight register writes with a 16-entry scoreboard and stalls decode on RAW/WAW hazards or when the in-flight limit is reached.
- Holds branches until both operands are clean, then issues a flush on a taken branch or jump.
- Sits between IF/ID and ID/EXE, alongside the register file and branch comparator; its writeback inputs mirror the register-file write port.

Parameters:
- MAX_INFLIGHT, 4, max outstanding register-writing instructions (1..15).
- FLUSH_CYCLES, 1, cycles flush stays high after a taken branch/jump (1..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  IF/ID holds a valid instruction.
- opcode  in  5  instruction[31:27].
- rs_dir  in  4  instruction[26:23].
- rt_dir  in  4  instruction[22:19].
- rd_dir  in  4  instruction[18:15].
- flag_branch  in  1  comparator equal flag (dataA == dataB).
- reg_wr  in  1  writeback commits this cycle.
- dir_wb  in  4  writeback destination register.
- issue  out  1  instruction advances to ID/EXE this cycle.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  load NOP into ID/EXE.
- flush  out  1  kill IF/ID contents.
- take_branch  out  1  select branch/jump target for PC, one-cycle pulse.
- pending  out  16  scoreboard, bit n = register n has a write in flight.
- inflight  out  4  outstanding writer count.
- wb_err  out  1  sticky error: writeback to a non-pending register.

Behaviour:
- Reset (async):
  - pending=0, inflight=0, wb_err=0.
  - State=RUN, flush=0, take_branch=0.
  - Flush counter cleared; any flush in progress is abandoned.
- Instruction classes, taken from the package:
  - ALU: reads rs, rt; writes rd.
  - LW: reads rs; writes rt.
  - SW: reads rs, rt; no write.
  - BEQ: reads rs, rt; no write.
  - JMP: no reads, no write.
  - NOP: no reads, no write.
  - Unlisted opcodes are treated as ALU.
- Hazard terms:
  - raw = any read source has its pending bit set.
  - waw = destination pending.
  - full = writer and inflight == MAX_INFLIGHT.
  - hazard = raw | waw | full.
- States: RUN, STALL, FLUSH.
- RUN:
  - instr_valid & hazard: stall=1, bubble=1, issue=0; next state STALL.
  - instr_valid & !hazard: issue=1, stall=0, bubble=0.
  - Taken BEQ (flag_branch=1) or any JMP on issue: take_branch=1 that same cycle; next state FLUSH.
  - instr_valid=0: all outputs 0 except the scoreboard outputs.
- STALL:
  - Hazard is re-evaluated every cycle against the current scoreboard, including a same-cycle writeback clear; this is combinational, with zero-cycle latency.
  - stall=1 and bubble=1 while hazard holds.
  - When hazard drops: issue as in RUN, and return to RUN or go to FLUSH.
  - instr_valid falling: return to RUN.
- FLUSH:
  - flush=1 for FLUSH_CYCLES consecutive cycles starting the cycle after take_branch.
  - issue=0, stall=0, bubble=1; instr_valid is ignored.
  - Return to RUN when the counter reaches FLUSH_CYCLES.
- Scoreboard update (registered):
  - Issue of a writer sets pending[dest].
  - reg_wr clears pending[dir_wb].
  - Same register set and cleared in one cycle: set wins, clear is dropped. Cannot occur legally, because waw would block it; count it as wb_err.
  - reg_wr to a non-pending register: no change to the scoreboard, wb_err set sticky until reset.
- inflight:
  - +1 on writer issue; −1 on a valid clear.
  - Both in one cycle: unchanged.
  - Never wraps below 0 or above MAX_INFLIGHT.
- All 16 registers, including r0, are tracked identically.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds output stall_cnt (32 bits), counting cycles with stall=1.
  - Adds output flush_cnt (32 bits), counting cycles with flush=1.
  - Both saturate at all-ones and are cleared by rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - opcode constants: OP_NOP=5'h00, OP_LW=5'h10, OP_SW=5'h11, OP_BEQ=5'h12, OP_JMP=5'h13;
  - the class enum (ALU/LW/SW/BEQ/JMP/NOP);
  - the state enum (RUN/STALL/FLUSH).
- One sub-module, hazard_scoreboard: pending bits, inflight counter and wb_err, with set/clear ports. The FSM and decode of classes stay in the top.

Test Plan:
- Reset: assert rst mid-FLUSH with pending=16'h0030 → next edge pending=0, inflight=0, flush=0; state RUN.
- RAW:
  - Issue ALU rd=3, then ALU rs=3 → stall=1, bubble=1 for every cycle until reg_wr with dir_wb=3.
  - Issue happens in that same cycle; pending[3] then clears.
- WAW/full, with MAX_INFLIGHT=2:
  - Issue LW rt=5, then ALU rd=6 → inflight=2.
  - Third writer rd=7 stalls until one writeback arrives.
  - A writer targeting rd=5 stalls until pending[5]=0.
- Branch: BEQ rs=1, rt=2 with pending[2]=1 → stall; after WB r2 with flag_branch=1 → issue=1, take_branch=1, then flush=1 for FLUSH_CYCLES cycles.
- Not-taken branch / JMP:
  - BEQ with flag_branch=0 → issue, no flush.
  - JMP → take_branch=1, flush next cycle, no scoreboard change.
- Error: reg_wr with dir_wb=9 while pending=0 → wb_err=1 stays set; inflight stays 0.
